// File: rtl/instr_assembler_if.sv
// Request/response bus of the instruction word assembler: decoded fields in,
// assembled word plus instruction-memory word address out.
interface instr_assembler_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_fmt;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [2:0]        in_funct3;
    logic [31:0]       in_imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_addr;

    // Producer of requests and consumer of assembled words
    modport master (
        output in_valid, in_fmt, in_rd, in_rs1, in_rs2, in_funct3, in_imm, out_ready,
        input  in_ready, out_valid, out_instr, out_addr
    );

    // The assembler itself
    modport slave (
        input  in_valid, in_fmt, in_rd, in_rs1, in_rs2, in_funct3, in_imm, out_ready,
        output in_ready, out_valid, out_instr, out_addr
    );
endinterface

// File: rtl/instr_assembler.sv
// Two-stage RISC-V I-load / S / B instruction word assembler. Stage 1 holds the
// range-checked request fields, stage 2 holds the scattered 32-bit word and the
// word address taken from a write pointer that advances on each output handshake.
// Illegal requests are consumed without entering the pipeline and are counted.
module instr_assembler #(
    parameter int ADDR_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    instr_assembler_if.slave bus,
    input  logic             addr_clr,
    output logic [7:0]       err_cnt,
    output logic [1:0]       err_code
);

    typedef enum logic [1:0] {
        FMT_LOAD   = 2'b00,
        FMT_STORE  = 2'b01,
        FMT_BRANCH = 2'b10,
        FMT_RSVD   = 2'b11
    } fmt_e;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'b00,
        ERR_RANGE = 2'b01,
        ERR_ALIGN = 2'b10,
        ERR_FMT   = 2'b11
    } err_e;

    // Only legal requests reach stage 1, so a 13-bit immediate covers every format.
    typedef struct packed {
        fmt_e        fmt;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [12:0] imm;
    } req_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // Handshake / flow-control terms
    logic s2_free;
    logic in_ready;
    logic in_hs;
    logic out_hs;
    logic s1_adv;

    // Incoming request decode
    fmt_e               in_fmt;
    logic signed [31:0] imm_s;
    err_e               chk_code;
    req_t               in_req;

    // Assembled word from stage 1 contents
    logic [31:0] asm_instr;

    // State
    logic              s1_valid_q, s1_valid_d;
    req_t              s1_req_q,   s1_req_d;
    logic              s2_valid_q, s2_valid_d;
    logic [31:0]       s2_instr_q, s2_instr_d;
    logic [ADDR_W-1:0] s2_addr_q,  s2_addr_d;
    logic [ADDR_W-1:0] ptr_q,      ptr_d;
    logic [7:0]        err_cnt_q,  err_cnt_d;
    err_e              err_code_q, err_code_d;

    // Flow control: stage 2 frees up when it drains, stage 1 when it moves on
    always_comb begin
        s2_free  = !s2_valid_q || bus.out_ready;
        in_ready = !s1_valid_q || s2_free;
        in_hs    = bus.in_valid && in_ready;
        out_hs   = s2_valid_q && bus.out_ready;
        s1_adv   = s1_valid_q && s2_free;
    end

    // Legality check of the offered request; the first failing rule names the cause
    always_comb begin
        in_fmt   = fmt_e'(bus.in_fmt);
        imm_s    = signed'(bus.in_imm);
        chk_code = ERR_NONE;
        if (in_fmt == FMT_RSVD) begin
            chk_code = ERR_FMT;
        end else if (in_fmt == FMT_BRANCH) begin
            if (bus.in_imm[0]) begin
                chk_code = ERR_ALIGN;
            end else if (imm_s < -32'sd4096 || imm_s > 32'sd4094) begin
                chk_code = ERR_RANGE;
            end
        end else if (imm_s < -32'sd2048 || imm_s > 32'sd2047) begin
            chk_code = ERR_RANGE;
        end

        in_req.fmt    = in_fmt;
        in_req.rd     = bus.in_rd;
        in_req.rs1    = bus.in_rs1;
        in_req.rs2    = bus.in_rs2;
        in_req.funct3 = bus.in_funct3;
        in_req.imm    = bus.in_imm[12:0];
    end

    // Scatter the stage-1 immediate into the bit layout of its format
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        asm_instr = '0;
        case (s1_req_q.fmt)
            FMT_LOAD:  asm_instr = {s1_req_q.imm[11:0], s1_req_q.rs1, s1_req_q.funct3,
                                   s1_req_q.rd, OP_LOAD};
            FMT_STORE: asm_instr = {s1_req_q.imm[11:5], s1_req_q.rs2, s1_req_q.rs1,
                                   s1_req_q.funct3, s1_req_q.imm[4:0], OP_STORE};
            default:   asm_instr = {s1_req_q.imm[12], s1_req_q.imm[10:5], s1_req_q.rs2,
                                   s1_req_q.rs1, s1_req_q.funct3, s1_req_q.imm[4:1],
                                   s1_req_q.imm[11], OP_BRANCH};
        endcase
    end

    // Next state of both stages, the write pointer and the error status
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_req_d   = s1_req_q;
        s2_valid_d = s2_valid_q;
        s2_instr_d = s2_instr_q;
        s2_addr_d  = s2_addr_q;
        ptr_d      = ptr_q;
        err_cnt_d  = err_cnt_q;
        err_code_d = err_code_q;

        // Clear beats a coincident handshake increment.
        if (addr_clr) begin
            ptr_d = '0;
        end else if (out_hs) begin
            ptr_d = ptr_q + ADDR_W'(1);
        end

        if (s1_adv) begin
            s1_valid_d = 1'b0;
        end
        if (in_hs) begin
            if (chk_code == ERR_NONE) begin
                s1_valid_d = 1'b1;
                s1_req_d   = in_req;
            end else begin
                err_code_d = chk_code;
                if (err_cnt_q != 8'hFF) begin
                    err_cnt_d = err_cnt_q + 8'd1;
                end
            end
        end

        // A word entering stage 2 takes the pointer value that will be current once
        // any word leaving stage 2 this cycle has been counted.
        if (out_hs) begin
            s2_valid_d = 1'b0;
        end
        if (s1_adv) begin
            s2_valid_d = 1'b1;
            s2_instr_d = asm_instr;
            s2_addr_d  = ptr_d;
        end
    end

    // State registers; reset empties both stages and clears pointer and status
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            s1_req_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_instr_q <= '0;
            s2_addr_q  <= '0;
            ptr_q      <= '0;
            err_cnt_q  <= '0;
            err_code_q <= ERR_NONE;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            s1_valid_q <= s1_valid_d;
            s1_req_q   <= s1_req_d;
            s2_valid_q <= s2_valid_d;
            s2_instr_q <= s2_instr_d;
            s2_addr_q  <= s2_addr_d;
            ptr_q      <= ptr_d;
            err_cnt_q  <= err_cnt_d;
            err_code_q <= err_code_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = s2_valid_q;
    assign bus.out_instr = s2_instr_q;
    assign bus.out_addr  = s2_addr_q;
    assign err_cnt       = err_cnt_q;
    assign err_code      = err_code_q;

endmodule

// File: tb/tb_instr_assembler.sv
// Bench for instr_assembler: two instances (8-bit and 2-bit address) share one
// stimulus stream; a queue-based model predicts words, addresses, flow control
// and error status, and directed literal expectations pin the model.
module tb_instr_assembler;

    typedef struct {
        logic [1:0]  fmt;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [31:0] imm;
    } req_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] imm;
        int          t;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        addr_clr = 1'b0;
    logic [1:0]  in_fmt = '0;
    logic [4:0]  in_rd = '0;
    logic [4:0]  in_rs1 = '0;
    logic [4:0]  in_rs2 = '0;
    logic [2:0]  in_funct3 = '0;
    logic [31:0] in_imm = '0;
    logic [7:0]  err_cnt8, err_cnt2;
    logic [1:0]  err_code8, err_code2;

    always #5 clk = ~clk;

    instr_assembler_if #(.ADDR_W(8)) bus8 ();
    instr_assembler_if #(.ADDR_W(2)) bus2 ();

    assign bus8.in_valid  = in_valid;
    assign bus8.in_fmt    = in_fmt;
    assign bus8.in_rd     = in_rd;
    assign bus8.in_rs1    = in_rs1;
    assign bus8.in_rs2    = in_rs2;
    assign bus8.in_funct3 = in_funct3;
    assign bus8.in_imm    = in_imm;
    assign bus8.out_ready = out_ready;
    assign bus2.in_valid  = in_valid;
    assign bus2.in_fmt    = in_fmt;
    assign bus2.in_rd     = in_rd;
    assign bus2.in_rs1    = in_rs1;
    assign bus2.in_rs2    = in_rs2;
    assign bus2.in_funct3 = in_funct3;
    assign bus2.in_imm    = in_imm;
    assign bus2.out_ready = out_ready;

    instr_assembler #(.ADDR_W(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .bus(bus8),
        .addr_clr(addr_clr), .err_cnt(err_cnt8), .err_code(err_code8)
    );

    instr_assembler #(.ADDR_W(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .bus(bus2),
        .addr_clr(addr_clr), .err_cnt(err_cnt2), .err_code(err_code2)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out waiting for the DUT", name);
    endtask

    // ---------------- model ----------------
    exp_t       q[$];
    int         cyc = 0;
    int         next_addr = 0;
    int         m_err_cnt = 0;
    logic [1:0] m_err_code = 2'b00;
    bit         chk_en = 1'b0;

    logic [31:0] log_instr[$];
    logic [7:0]  log_a8[$];
    logic [1:0]  log_a2[$];

    function automatic req_t mk(input int fmt, input int rd, input int rs1, input int rs2,
                                input int f3, input int imm);
        req_t r;
        r.fmt = 2'(fmt);
        r.rd  = 5'(rd);
        r.rs1 = 5'(rs1);
        r.rs2 = 5'(rs2);
        r.f3  = 3'(f3);
        r.imm = 32'(imm);
        return r;
    endfunction

    function automatic logic [1:0] legal_code(input req_t r);
        int v;
        v = $signed(r.imm);
        if (r.fmt == 2'b11) return 2'b11;
        if (r.fmt == 2'b10) begin
            if (r.imm[0]) return 2'b10;
            return (v < -4096 || v > 4094) ? 2'b01 : 2'b00;
        end
        return (v < -2048 || v > 2047) ? 2'b01 : 2'b00;
    endfunction

    // Field placement by shift-and-mask arithmetic on the immediate
    function automatic logic [31:0] encode(input req_t r);
        logic [31:0] u;
        logic [31:0] base;
        u    = r.imm;
        base = (32'(r.rs1) << 15) | (32'(r.f3) << 12);
        case (r.fmt)
            2'b00:   return ((u & 32'hFFF) << 20) | base | (32'(r.rd) << 7) | 32'h03;
            2'b01:   return (((u >> 5) & 32'h7F) << 25) | (32'(r.rs2) << 20) | base |
                            ((u & 32'h1F) << 7) | 32'h23;
            default: return (((u >> 12) & 32'h1) << 31) | (((u >> 5) & 32'h3F) << 25) |
                            (32'(r.rs2) << 20) | base | (((u >> 1) & 32'hF) << 8) |
                            (((u >> 11) & 32'h1) << 7) | 32'h63;
        endcase
    endfunction

    // Core-side immediate generator, used to round-trip every emitted word
    function automatic logic [31:0] decode_imm(input logic [31:0] w);
        logic [31:0] r;
        r = '1;
        case (w[6:0])
            7'h03:   r = {{20{w[31]}}, w[31:20]};
            7'h23:   r = {{20{w[31]}}, w[31:25], w[11:7]};
            7'h63:   r = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            default: r = '1;
        endcase
        return r;
    endfunction

    req_t       cur_r;
    exp_t       cur_e;
    logic       exp_ov, exp_ir;
    logic [1:0] cur_code;

    // Compare process: outputs are checked mid-cycle, then the model takes this cycle's handshakes
    always @(negedge clk) begin
        if (chk_en) begin
            cyc++;
            exp_ov = (q.size() > 0) && (q[0].t + 2 <= cyc);
            exp_ir = !((q.size() == 2) && !out_ready);
            check("out_valid8", 32'(bus8.out_valid), 32'(exp_ov));
            check("out_valid2", 32'(bus2.out_valid), 32'(exp_ov));
            check("in_ready8", 32'(bus8.in_ready), 32'(exp_ir));
            check("in_ready2", 32'(bus2.in_ready), 32'(exp_ir));
            if (exp_ov) begin
                check("out_instr8", bus8.out_instr, q[0].instr);
                check("out_instr2", bus2.out_instr, q[0].instr);
                check("out_addr8", 32'(bus8.out_addr), 32'(next_addr % 256));
                check("out_addr2", 32'(bus2.out_addr), 32'(next_addr % 4));
                check("imm_roundtrip", decode_imm(bus8.out_instr), q[0].imm);
            end
            check("err_cnt8", 32'(err_cnt8), 32'(m_err_cnt));
            check("err_cnt2", 32'(err_cnt2), 32'(m_err_cnt));
            check("err_code8", 32'(err_code8), 32'(m_err_code));
            check("err_code2", 32'(err_code2), 32'(m_err_code));

            if (bus8.out_valid && out_ready) begin
                log_instr.push_back(bus8.out_instr);
                log_a8.push_back(bus8.out_addr);
                log_a2.push_back(bus2.out_addr);
            end

            if (exp_ov && out_ready) begin
                void'(q.pop_front());
                next_addr = addr_clr ? 0 : (next_addr + 1) % 256;
            end else if (addr_clr) begin
                next_addr = 0;
            end
            if (in_valid && exp_ir) begin
                cur_r    = mk(int'(in_fmt), int'(in_rd), int'(in_rs1), int'(in_rs2),
                              int'(in_funct3), int'(in_imm));
                cur_code = legal_code(cur_r);
                if (cur_code == 2'b00) begin
                    cur_e.instr = encode(cur_r);
                    cur_e.imm   = cur_r.imm;
                    cur_e.t     = cyc;
                    q.push_back(cur_e);
                end else begin
                    m_err_code = cur_code;
                    if (m_err_cnt < 255) m_err_cnt++;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input req_t r);
        int n;
        n = 0;
        in_fmt    = r.fmt;
        in_rd     = r.rd;
        in_rs1    = r.rs1;
        in_rs2    = r.rs2;
        in_funct3 = r.f3;
        in_imm    = r.imm;
        in_valid  = 1'b1;
        forever begin
            @(negedge clk);
            if (bus8.in_ready) break;
            n++;
            if (n > 50) begin
                timeout_fail("send");
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (q.size() != 0) begin
            @(negedge clk);
            n++;
            if (n > 100) begin
                timeout_fail("drain");
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        chk_en   = 1'b0;
        in_valid = 1'b0;
        addr_clr = 1'b0;
        reset_n  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        q.delete();
        cyc        = 0;
        next_addr  = 0;
        m_err_cnt  = 0;
        m_err_code = 2'b00;
        chk_en     = 1'b1;
    endtask

    task automatic clear_log();
        log_instr.delete();
        log_a8.delete();
        log_a2.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    req_t bp_reqs[3];
    int   bp_idx;
    bit   bp_acc;

    initial begin
        // Reset state
        do_reset();
        check("rst_out_valid", 32'(bus8.out_valid), 32'd0);
        check("rst_out_instr", bus8.out_instr, 32'd0);
        check("rst_out_addr", 32'(bus8.out_addr), 32'd0);
        check("rst_err_cnt", 32'(err_cnt8), 32'd0);
        check("rst_err_code", 32'(err_code8), 32'd0);
        check("rst_in_ready", 32'(bus8.in_ready), 32'd1);

        // Basic words and two-cycle latency
        clear_log();
        out_ready = 1'b1;
        send(mk(0, 5, 2, 0, 3'b010, -4));
        @(negedge clk);
        check("lat_n1_valid", 32'(bus8.out_valid), 32'd0);
        @(negedge clk);
        check("lat_n2_valid", 32'(bus8.out_valid), 32'd1);
        check("ld_word", bus8.out_instr, 32'hFFC12283);
        check("ld_addr", 32'(bus8.out_addr), 32'd0);
        @(posedge clk);
        #1;
        send(mk(1, 0, 2, 8, 3'b010, 12));
        send(mk(2, 0, 1, 2, 3'b000, -8));
        wait_drain();
        check("basic_count", 32'(log_instr.size()), 32'd3);
        check("st_word", log_instr[1], 32'h00812623);
        check("br_word", log_instr[2], 32'hFE208CE3);
        check("st_addr", 32'(log_a8[1]), 32'd1);
        check("br_addr", 32'(log_a8[2]), 32'd2);

        // Illegal requests, back to back, then boundary illegals and saturation
        send(mk(2, 0, 1, 2, 0, 5));
        check("ill_align_code", 32'(err_code8), 32'd2);
        check("ill_align_cnt", 32'(err_cnt8), 32'd1);
        send(mk(0, 1, 1, 0, 0, 2048));
        check("ill_range_code", 32'(err_code8), 32'd1);
        send(mk(3, 1, 1, 1, 0, 0));
        check("ill_fmt_code", 32'(err_code8), 32'd3);
        check("ill_cnt3", 32'(err_cnt8), 32'd3);
        repeat (3) @(negedge clk);
        check("ill_no_output", 32'(log_instr.size()), 32'd3);
        @(posedge clk);
        #1;
        send(mk(1, 0, 3, 4, 0, -2049));
        send(mk(2, 0, 3, 4, 0, 4096));
        send(mk(2, 0, 3, 4, 0, -4098));
        check("ill_cnt6", 32'(err_cnt8), 32'd6);
        for (int i = 0; i < 256; i++) begin
            send(mk(3, i % 32, 0, 0, 0, i));
        end
        check("ill_sat", 32'(err_cnt8), 32'd255);
        check("ill_sat2", 32'(err_cnt2), 32'd255);

        // Legal boundary immediates; pointer must have survived the illegals
        send(mk(1, 0, 7, 9, 3'b001, -2048));
        send(mk(0, 31, 31, 0, 3'b111, 2047));
        send(mk(2, 0, 4, 5, 3'b101, 4094));
        send(mk(2, 0, 6, 7, 3'b100, -4096));
        wait_drain();
        check("bound_count", 32'(log_instr.size()), 32'd7);
        check("ptr_unchanged", 32'(log_a8[3]), 32'd3);
        check("ptr_unchanged2", 32'(log_a2[3]), 32'd3);

        // Both stages full, then asynchronous reset
        out_ready = 1'b0;
        send(mk(0, 1, 2, 0, 0, 100));
        send(mk(1, 0, 2, 3, 0, 200));
        @(negedge clk);
        check("full_out_valid", 32'(bus8.out_valid), 32'd1);
        check("full_in_ready", 32'(bus8.in_ready), 32'd0);
        #2;
        chk_en  = 1'b0;
        reset_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(bus8.out_valid), 32'd0);
        check("async_rst_instr", bus8.out_instr, 32'd0);
        do_reset();
        check("post_rst_err_cnt", 32'(err_cnt8), 32'd0);
        check("post_rst_err_code", 32'(err_code8), 32'd0);

        // Backpressure: four stalled cycles with three requests offered
        clear_log();
        bp_reqs[0] = mk(0, 5, 2, 0, 3'b010, -4);
        bp_reqs[1] = mk(1, 0, 2, 8, 3'b010, 12);
        bp_reqs[2] = mk(2, 0, 1, 2, 3'b000, -8);
        bp_idx = 0;
        for (int c = 0; c < 4; c++) begin
            in_fmt    = bp_reqs[bp_idx].fmt;
            in_rd     = bp_reqs[bp_idx].rd;
            in_rs1    = bp_reqs[bp_idx].rs1;
            in_rs2    = bp_reqs[bp_idx].rs2;
            in_funct3 = bp_reqs[bp_idx].f3;
            in_imm    = bp_reqs[bp_idx].imm;
            in_valid  = 1'b1;
            @(negedge clk);
            bp_acc = bus8.in_ready;
            if (c >= 2) begin
                check("bp_in_ready", 32'(bus8.in_ready), 32'd0);
                check("bp_stable", bus8.out_instr, 32'hFFC12283);
            end
            @(posedge clk);
            #1;
            if (bp_acc) bp_idx++;
        end
        check("bp_accepted", 32'(bp_idx), 32'd2);
        out_ready = 1'b1;
        send(bp_reqs[2]);
        wait_drain();
        check("bp_count", 32'(log_instr.size()), 32'd3);
        check("bp_w0", log_instr[0], 32'hFFC12283);
        check("bp_w1", log_instr[1], 32'h00812623);
        check("bp_w2", log_instr[2], 32'hFE208CE3);
        check("bp_a0", 32'(log_a8[0]), 32'd0);
        check("bp_a1", 32'(log_a8[1]), 32'd1);
        check("bp_a2", 32'(log_a8[2]), 32'd2);

        // Pointer wrap on the 2-bit instance
        do_reset();
        clear_log();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send(mk(i % 3, i + 1, i + 2, i + 3, i, 4 * i - 8));
        end
        wait_drain();
        check("wrap_count", 32'(log_a2.size()), 32'd5);
        check("wrap_a0", 32'(log_a2[0]), 32'd0);
        check("wrap_a1", 32'(log_a2[1]), 32'd1);
        check("wrap_a2", 32'(log_a2[2]), 32'd2);
        check("wrap_a3", 32'(log_a2[3]), 32'd3);
        check("wrap_a4", 32'(log_a2[4]), 32'd0);
        check("wrap_a4_8", 32'(log_a8[4]), 32'd4);

        // Clear coincident with the handshake of the address-1 word
        do_reset();
        clear_log();
        out_ready = 1'b0;
        send(mk(0, 1, 1, 0, 0, 16));
        send(mk(1, 0, 1, 2, 0, 32));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        addr_clr = 1'b1;
        @(posedge clk);
        #1;
        addr_clr = 1'b0;
        send(mk(2, 0, 1, 2, 0, 64));
        wait_drain();
        check("clr_count", 32'(log_a8.size()), 32'd3);
        check("clr_a0", 32'(log_a8[0]), 32'd0);
        check("clr_a1", 32'(log_a8[1]), 32'd1);
        check("clr_a2", 32'(log_a8[2]), 32'd0);
        check("clr_a2_2", 32'(log_a2[2]), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_assembler.md
# instr_assembler

Pipelined RISC-V instruction word assembler for the load/store/branch formats (I-load, S, B) used by the core's immediate path. It accepts decoded fields plus a signed byte-offset immediate, range-checks the immediate, scatters it into the format's bit layout, and emits the 32-bit word with a sequential instruction-memory word address. It sits on the program-load path ahead of instruction memory and is the encode-side counterpart of the core's immediate generator.

## Interface
- ADDR_W, 8, width of instruction-memory word address / write pointer

- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  request present
- in_ready  out  1  request accepted when in_valid && in_ready
- in_fmt  in  2  00 I-load, 01 S, 10 B, 11 reserved (illegal)
- in_rd  in  5  destination register (I-load only)
- in_rs1  in  5  source 1
- in_rs2  in  5  source 2 (S, B)
- in_funct3  in  3  funct3 field
- in_imm  in  32  signed byte offset (two's complement)
- addr_clr  in  1  synchronous write-pointer clear
- out_valid  out  1  assembled word present
- out_ready  in  1  consumer accepts when out_valid && out_ready
- out_instr  out  32  assembled instruction
- out_addr  out  ADDR_W  word address for out_instr
- err_cnt  out  8  saturating count of dropped requests
- err_code  out  2  cause of most recent drop: 01 range, 10 misaligned, 11 bad fmt

## Operation
- Opcodes: I-load 0000011, S 0100011, B 1100011.
- I-load: {imm[11:0], rs1, funct3, rd, opcode}.
- S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
- B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
- Legality, checked at acceptance, priority: fmt 11 → code 11; B with imm[0]=1 → code 10; I/S imm outside [-2048, 2047] or B imm outside [-4096, 4094] → code 01.
- Illegal request: handshakes normally, never enters the pipeline, produces no output, leaves the write pointer unchanged. err_code is latched, and err_cnt increments and saturates at 255.
- Stage 1 registers the legal fields. Stage 2 registers the assembled word plus out_addr.
- Write pointer increments on every output handshake and wraps from 2^ADDR_W-1 to 0. out_addr is the pointer value attached when the word enters stage 2 (in-order).
- addr_clr sets the pointer to 0. Coincident with an output handshake, clear wins: the next word gets address 0. Words already in stage 2 keep their address.

## Timing
- Reset (async assert, sync release): out_valid=0, out_instr=0, out_addr=0, err_cnt=0, err_code=00, both stage valids=0, pointer=0. in_ready=1 after reset.
- Latency: legal request accepted in cycle N → out_valid in cycle N+2 if unstalled. Throughput 1 word/cycle.
- s2_free = !s2_valid || out_ready.
- in_ready = !s1_valid || s2_free. This is a combinational path from out_ready.
- Stage 1 advances to stage 2 when s1_valid && s2_free.
- out_instr and out_addr hold stable while out_valid && !out_ready.
- Both stages full with out_ready=0: in_ready=0. No request is lost or duplicated.
- err_cnt and err_code update the cycle after the illegal handshake.
- Reset mid-stream discards both stages immediately.

## Test plan
- I-load rd=5, rs1=2, funct3=010, imm=-4 → out_instr 0xFFC12283, out_addr 0, two cycles after acceptance.
- S rs1=2, rs2=8, funct3=010, imm=12 → 0x00812623. B rs1=1, rs2=2, funct3=000, imm=-8 → 0xFE208CE3. Round-trip through the core immediate generator returns in_imm.
- Illegal B imm=5, I imm=2048, fmt 11 back-to-back → err_code 10, then 01, then 11. Ends with err_cnt=3, no out_valid, pointer unchanged. Then 256 further illegal requests → err_cnt holds 255.
- Backpressure: out_ready=0 for 4 cycles with 3 legal requests offered → exactly 2 accepted, in_ready low, out_instr stable. Release → words drain in order at addresses 0, 1, 2.
- ADDR_W=2, 5 legal words → addresses 0, 1, 2, 3, 0. addr_clr pulsed during the handshake of the address-1 word → next word gets address 0.
- reset_n asserted with both stages full → out_valid drops asynchronously. After release, the first new word gets address 0 and err_cnt is 0.
